// File: rtl/mips_pkg.sv
// Shared MIPS pipeline definitions: register index width,
// control word layout, NOP control and ALU op encodings.
package mips_pkg;

  localparam int REG_W = 5;
  localparam logic [REG_W-1:0] ZERO_REG = '0;

  localparam int CTRL_W = 9;

  localparam int CTRL_REGWRITE = 8;
  localparam int CTRL_MEMREAD  = 7;
  localparam int CTRL_MEMWRITE = 6;
  localparam int CTRL_MEMTOREG = 5;
  localparam int CTRL_ALUSRC   = 4;
  localparam int CTRL_REGDST   = 3;
  localparam int CTRL_ALUOP_LO = 0;

  typedef enum logic [2:0] {
    ALU_ADD  = 3'b000,
    ALU_SUB  = 3'b001,
    ALU_FUNC = 3'b010,
    ALU_AND  = 3'b011,
    ALU_OR   = 3'b100,
    ALU_SLT  = 3'b101,
    ALU_LUI  = 3'b110,
    ALU_XOR  = 3'b111
  } alu_op_e;

  typedef struct packed {
    logic    reg_write;
    logic    mem_read;
    logic    mem_write;
    logic    mem_to_reg;
    logic    alu_src;
    logic    reg_dst;
    alu_op_e alu_op;
  } ctrl_t;

  localparam logic [CTRL_W-1:0] CTRL_NOP = '0;

endpackage

// File: rtl/hazard_detect.sv
// Load-use hazard detector: flags when the load in EX
// writes a register the instruction in ID reads.
module hazard_detect #(
  parameter int REG_W = 5
) (
  input  logic             mem_read,
  input  logic [REG_W-1:0] ex_rt,
  input  logic [REG_W-1:0] id_rs,
  input  logic [REG_W-1:0] id_rt,
  input  logic             uses_rt,
  output logic             hz
);

  logic rs_hit;
  logic rt_hit;

  assign rs_hit = (ex_rt == id_rs);
  assign rt_hit = uses_rt & (ex_rt == id_rt);

  // register 0 is hardwired, so a load into it never conflicts
  assign hz = mem_read & (ex_rt != '0) & (rs_hit | rt_hit);

endmodule

// File: rtl/id_ex_stage.sv
// ID/EX register with load-use bubble insertion and flush.
// Optional HAZ_STALL_CNT_EN adds a saturating StallCount output.
module id_ex_stage
  import mips_pkg::*;
#(
  parameter int DATA_W = 32,
  parameter int REG_W  = 5
) (
  input  logic              clk,
  input  logic              rst,
  input  logic [REG_W-1:0]  IdRs,
  input  logic [REG_W-1:0]  IdRt,
  input  logic [REG_W-1:0]  IdRd,
  input  logic              IdUsesRt,
  input  logic [DATA_W-1:0] IdData1,
  input  logic [DATA_W-1:0] IdData2,
  input  logic [DATA_W-1:0] IdImm,
  input  logic [CTRL_W-1:0] IdCtrl,
  input  logic              IdFlush,
  input  logic              Freeze,
  output logic [REG_W-1:0]  ExRs,
  output logic [REG_W-1:0]  ExRt,
  output logic [REG_W-1:0]  ExRd,
  output logic [DATA_W-1:0] ExData1,
  output logic [DATA_W-1:0] ExData2,
  output logic [DATA_W-1:0] ExImm,
  output logic [CTRL_W-1:0] ExCtrl,
  output logic              Stall,
  output logic              PcWrite,
  output logic              IfIdWrite
`ifdef HAZ_STALL_CNT_EN
  ,
  output logic [15:0]       StallCount
`endif
);

  logic hz;
  logic bubble;

  hazard_detect #(
    .REG_W(REG_W)
  ) u_hazard (
    .mem_read(ExCtrl[CTRL_MEMREAD]),
    .ex_rt   (ExRt),
    .id_rs   (IdRs),
    .id_rt   (IdRt),
    .uses_rt (IdUsesRt),
    .hz      (hz)
  );

  // flush with a pending hazard still holds PC/IF-ID,
  // so the branch resolves again once the stall clears
  assign bubble    = hz | IdFlush;
  assign Stall     = hz & ~Freeze;
  assign PcWrite   = ~(hz | Freeze);
  assign IfIdWrite = ~(hz | Freeze);

  // pipeline register: reset, freeze hold, bubble, then load
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      ExRs    <= '0;
      ExRt    <= '0;
      ExRd    <= '0;
      ExData1 <= '0;
      ExData2 <= '0;
      ExImm   <= '0;
      ExCtrl  <= CTRL_NOP;
    end else if (Freeze) begin
      ExRs    <= ExRs;
      ExRt    <= ExRt;
      ExRd    <= ExRd;
      ExData1 <= ExData1;
      ExData2 <= ExData2;
      ExImm   <= ExImm;
      ExCtrl  <= ExCtrl;
    end else if (bubble) begin
      ExRs    <= '0;
      ExRt    <= '0;
      ExRd    <= '0;
      ExData1 <= '0;
      ExData2 <= '0;
      ExImm   <= '0;
      ExCtrl  <= CTRL_NOP;
    end else begin
      ExRs    <= IdRs;
      ExRt    <= IdRt;
      ExRd    <= IdRd;
      ExData1 <= IdData1;
      ExData2 <= IdData2;
      ExImm   <= IdImm;
      ExCtrl  <= IdCtrl;
    end
  end

`ifdef HAZ_STALL_CNT_EN
  logic [15:0] stall_cnt;

  // count hazard bubbles only, saturating at all-ones
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      stall_cnt <= '0;
    end else if (Stall && stall_cnt != 16'hFFFF) begin
      stall_cnt <= stall_cnt + 16'd1;
    end
  end

  assign StallCount = stall_cnt;
`endif

endmodule

// File: doc/id_ex_stage.md
# id_ex_stage

ID/EX pipeline stage of the 5-stage MIPS core: load-use hazard detection plus the ID/EX pipeline register. Samples decoded operands and control from ID each cycle and presents them to EX, where `ExRs`/`ExRt` feed the forwarding unit and the data/immediate feed the ALU input muxes. Inserts a one-cycle bubble on a load-use dependency or branch flush. Freezes PC and IF/ID during a load-use bubble.

## Interface
Parameters:
- `DATA_W`, 32, operand/immediate width
- `REG_W`, 5, register-index width

Ports (one clock; reset asynchronous, active-high):
- `clk` in 1: pipeline clock, rising edge
- `rst` in 1: async active-high reset
- `IdRs`, `IdRt`, `IdRd` in REG_W: decoded register indices
- `IdUsesRt` in 1: instruction reads Rt as a source (R-type, store, beq)
- `IdData1`, `IdData2` in DATA_W: register-file read data
- `IdImm` in DATA_W: sign-extended immediate
- `IdCtrl` in 9: {RegWrite, MemRead, MemWrite, MemToReg, AluSrc, RegDst, AluOp[2:0]}
- `IdFlush` in 1: branch taken in ID; kill the instruction entering EX
- `Freeze` in 1: external global stall (memory wait); hold stage contents
- `ExRs`, `ExRt`, `ExRd` out REG_W: registered indices to EX/forwarding unit
- `ExData1`, `ExData2`, `ExImm` out DATA_W: registered operands
- `ExCtrl` out 9: registered control
- `Stall` out 1: load-use bubble this cycle
- `PcWrite`, `IfIdWrite` out 1: enable for PC and IF/ID register

## Operation
- Hazard (combinational): `Hz = ExCtrl.MemRead & (ExRt != 0) & ((ExRt == IdRs) | (IdUsesRt & (ExRt == IdRt)))`.
- `Stall = Hz & ~Freeze`. `PcWrite = IfIdWrite = ~(Hz | Freeze)`.
- Register update priority on each rising edge:
  1. `rst`: all registered outputs clear to 0; `ExCtrl`=0 is a NOP.
  2. `Freeze`: hold every register.
  3. `Hz | IdFlush`: load a bubble. `ExCtrl` <= 0; indices and data <= 0. Zeroed indices keep the forwarding unit inert.
  4. Otherwise: load all ID fields.
- Flush and hazard together: the bubble is inserted and PC/IF-ID are held. The branch re-resolves once the stall ends; flush is not lost.
- Bubble contents: `ExRt`=0. The next cycle therefore cannot re-detect a hazard, so a load-use stall is exactly one cycle.
- Register index 0 never triggers a hazard.

## Timing
- Latency: 1 cycle ID→EX.
- `Stall`, `PcWrite`, `IfIdWrite` are combinational from registered `ExCtrl`/`ExRt` and the current ID fields, and are valid in the same cycle.
- Reset values: all `Ex*` = 0. `Stall`=0. `PcWrite`=`IfIdWrite`=1 (unless `Freeze`).
- Reset asserted mid-stall: state clears immediately (asynchronous). The first cycle after release has no hazard.
- `Freeze` during a pending hazard: `Stall`=0 and contents are held. The hazard re-evaluates when `Freeze` drops.

## Configuration
- `HAZ_STALL_CNT_EN` defined: adds output `StallCount` [15:0]. It is a saturating counter incremented on each rising edge where a bubble is loaded because of `Hz` (not flush-only, not during `Freeze`). Cleared by `rst`, holds at 16'hFFFF.
- Undefined: port and counter absent; all other behaviour identical.

## Structure
- Shared package `mips_pkg`:
  - `REG_W`, `ZERO_REG`
  - control struct/field offsets for the 9-bit control word
  - `CTRL_NOP` = 0
  - AluOp encodings
- One sub-module: `hazard_detect` (combinational `Hz` equation). It is instantiated here and reusable by a later branch-hazard extension.
- The register and priority logic live in `id_ex_stage`.

## Test plan
- Reset: assert `rst` asynchronously mid-cycle → all `Ex*`=0 immediately; `PcWrite`=`IfIdWrite`=1, `Stall`=0.
- Load-use stall:
  - Stimulus: `lw $8` in EX (`ExCtrl.MemRead`=1, `ExRt`=8), ID `add` with `IdRs`=8.
  - Required: `Stall`=1, `PcWrite`=0. Next edge `ExCtrl`=0, `ExRt`=0. Following cycle `Stall`=0 and the add loads.
- Rt gating:
  - `ExRt`=8 load, `IdRt`=8, `IdUsesRt`=0 → no stall.
  - Same with `IdUsesRt`=1 → stall.
  - `ExRt`=0 load with `IdRs`=0 → no stall.
- Flush: `IdFlush`=1, no hazard, ID fields `IdRd`=5, `IdImm`=32'h1234 → next `ExCtrl`=0, `ExRd`=0, `ExImm`=0; `PcWrite` stays 1.
- Freeze: `Freeze`=1 for 3 cycles with changing ID inputs → `Ex*` unchanged, `PcWrite`=0, `Stall`=0. After release, the first edge loads current ID fields.
- `HAZ_STALL_CNT_EN`: 3 load-use stalls, 1 flush, 2 frozen cycles → `StallCount`=3. Preload near max and stall → saturates at 16'hFFFF.
